uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Packet-level controller sitting directly behind the UART receiver. It consumes the receiver's byte stream (byte, valid pulse, frame-error pulse) and sequences it into command packets: sync hunt, header, bounded payload, checksum. Validated packets are exposed to the command/register logic via a hold-until-acknowledged handshake and a payload read port. Framing, length, checksum and inter-byte-timeout errors are flagged with one-cycle pulses.

## Interface
- SYNC_BYTE, 8'hAA, packet start marker
- MAX_LEN, 16, maximum payload bytes (1..255)
- TIMEOUT_CYCLES, 8680, idle clocks allowed between bytes inside a packet (about 2 byte times at 115200 baud, 50 MHz)
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  one-cycle pulse, rx_data valid
- rx_ferr  in  1  one-cycle pulse, receiver stop-bit error
- pkt_valid  out  1  packet available; held until pkt_ack
- pkt_ack  in  1  consumer releases packet
- pkt_cmd  out  8  command byte of held packet
- pkt_len  out  8  payload length of held packet
- rd_addr  in  8  payload read index
- rd_data  out  8  payload byte at rd_addr (combinational); 0 if rd_addr >= MAX_LEN
- err_chk / err_len / err_frame / err_timeout  out  1 each  one-cycle error pulses
- drop_cnt  out  8  saturating count of bytes discarded while a packet is held
- state  out  3  current FSM state, debug only

## Operation
- Frame format: SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK. CHK must equal (CMD + LEN + sum of payload) mod 256.
- FSM states and encodings: HUNT=0, CMD=1, LEN=2, PAYLOAD=3, CHK=4, HOLD=5.
- HUNT: on rx_valid with rx_data==SYNC_BYTE, go to CMD. All other bytes are discarded silently.
- CMD: on rx_valid, latch the command and seed the running sum with it; go to LEN.
- LEN: on rx_valid, if the byte exceeds MAX_LEN, pulse err_len and go to HUNT. If it is 0, go to CHK. Otherwise go to PAYLOAD with byte index 0. The length is added to the running sum.
- PAYLOAD: on each rx_valid, write buf[idx], add the byte to the sum and increment idx. After byte LEN-1, go to CHK.
- CHK: on rx_valid, on a match go to HOLD and assert pkt_valid. On a mismatch, pulse err_chk and go to HUNT.
- HOLD: pkt_valid=1. pkt_cmd, pkt_len and the buffer are stable. Bytes arriving here are dropped and increment drop_cnt, which saturates at 255 and is cleared only by reset. When pkt_ack=1, go to HUNT next cycle.
- rx_ferr in CMD, LEN, PAYLOAD or CHK: pulse err_frame and go to HUNT. In HUNT or HOLD it is ignored.
- If rx_ferr and rx_valid arrive in the same cycle, rx_ferr wins and the byte is discarded.
- Timeout counter:
  - Cleared on every rx_valid and whenever the FSM is in HUNT or HOLD.
  - In CMD through CHK, reaching TIMEOUT_CYCLES-1 pulses err_timeout and returns the FSM to HUNT.
  - If rx_valid coincides with the terminal count, the byte wins and no timeout occurs.
- A SYNC_BYTE value in CMD, LEN, payload or CHK position is treated as data; it does not resynchronise the parser.
- pkt_ack while pkt_valid=0 is ignored.
- Reset mid-packet aborts the packet; the partial packet is never presented.

## Timing
- Reset values: pkt_valid=0, pkt_cmd=0, pkt_len=0, all err_*=0, drop_cnt=0, state=HUNT. Buffer contents are undefined until written.
- All transitions occur on the clk edge that samples rx_valid.
- pkt_valid rises the cycle after the CHK byte's rx_valid.
- Error pulses assert the cycle after the offending event and last exactly one cycle.
- pkt_valid falls the cycle after pkt_ack is sampled high. The next packet's sync byte is accepted from that cycle onward.
- rd_data has zero-cycle latency from rd_addr.

## Configuration
- UART_CMD_PARSER_TIMEOUT_EN defined: the timeout counter and err_timeout logic are built as described above.
- UART_CMD_PARSER_TIMEOUT_EN undefined: no counter is instantiated and err_timeout is tied to 0. A stalled packet waits indefinitely for its next byte; only rx_ferr or reset recovers it.

## Test plan
- Send AA 10 02 01 02 15 -> pkt_valid=1 one cycle after the last byte, pkt_cmd=0x10, pkt_len=2, rd_data[0]=0x01, rd_data[1]=0x02. Assert pkt_ack -> pkt_valid=0 next cycle, state=HUNT.
- Send AA 10 02 01 02 16 -> err_chk pulses once; pkt_valid stays 0. A following AA 20 00 20 -> pkt_valid=1, pkt_cmd=0x20, pkt_len=0.
- Send AA 30 11 (MAX_LEN=16) -> err_len pulse; subsequent non-AA bytes are ignored with no errors.
- Send AA 40, then no byte for TIMEOUT_CYCLES clocks -> err_timeout pulses exactly once, state=HUNT. With the macro undefined, state stays 2 indefinitely.
- Hold a valid packet without ack, then send 300 bytes -> drop_cnt=255 (saturated), and packet contents are unchanged.
- Assert rx_ferr during PAYLOAD -> err_frame pulse, state=HUNT. Assert rst_n low mid-payload -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Packet sequencer behind the UART receiver. It hunts for the sync byte and
// collects the command, the length, a bounded payload and an additive
// checksum. A validated packet is held for the consumer until it is acked.
// Framing, length, checksum and inter-byte timeout errors are reported as
// one-cycle pulses.
//
// Build option: define UART_CMD_PARSER_TIMEOUT_EN to build the inter-byte
// timeout counter and err_timeout. Without it err_timeout is tied low and a
// stalled packet waits until rx_ferr or reset. TIMEOUT_CYCLES only exists
// as a parameter when the counter is built.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// HUNT    (0)| discard bytes until SYNC_BYTE
// CMD     (1)| next byte is the command; seeds the running sum
// LEN     (2)| next byte is the payload length (0..MAX_LEN)
// PAYLOAD (3)| storing payload bytes into the buffer
// CHK     (4)| next byte is compared with the running sum
// HOLD    (5)| packet presented on pkt_valid; incoming bytes are dropped

module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hAA,
    parameter int         MAX_LEN        = 16
`ifdef UART_CMD_PARSER_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 8680
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_ferr,
    output logic       pkt_valid,
    input  logic       pkt_ack,
    output logic [7:0] pkt_cmd,
    output logic [7:0] pkt_len,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_frame,
    output logic       err_timeout,
    output logic [7:0] drop_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state_q;
    state_t     state_d;

    logic [7:0] cmd_q;
    logic [7:0] len_q;
    logic [7:0] sum_q;
    logic [7:0] idx_q;
    logic [7:0] pay_mem [MAX_LEN];

    logic       in_packet;
    logic       byte_ok;

    logic       err_chk_q;
    logic       err_len_q;
    logic       err_frame_q;
    logic       err_chk_d;
    logic       err_len_d;
    logic       err_frame_d;

    // A byte that arrives together with a frame error is discarded.
    assign byte_ok   = rx_valid && !rx_ferr;
    assign in_packet = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                       (state_q == ST_PAYLOAD) || (state_q == ST_CHK);

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             err_tmo_q;
    logic             err_tmo_d;

    // Inter-byte down-counter: reloads on every byte and outside a packet,
    // terminal count is zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= TMO_LOAD;
        end else if (!in_packet || rx_valid || (tmo_cnt == '0)) begin
            tmo_cnt <= TMO_LOAD;
        end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
        end
    end

    // A byte landing on the terminal count keeps the packet alive.
    assign tmo_hit = in_packet && !rx_valid && (tmo_cnt == '0);

    // Timeout pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_tmo_q <= 1'b0;
        end else begin
            err_tmo_q <= err_tmo_d;
        end
    end

    assign err_timeout = err_tmo_q;
`else
    assign err_timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and error-pulse decode; frame error beats timeout beats data.
    always_comb begin
        state_d     = state_q;
        err_chk_d   = 1'b0;
        err_len_d   = 1'b0;
        err_frame_d = 1'b0;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
        err_tmo_d   = 1'b0;
`endif
        if (in_packet && rx_ferr) begin
            state_d     = ST_HUNT;
            err_frame_d = 1'b1;
        end
`ifdef UART_CMD_PARSER_TIMEOUT_EN
        else if (tmo_hit) begin
            state_d   = ST_HUNT;
            err_tmo_d = 1'b1;
        end
`endif
        else begin
            case (state_q)
                ST_HUNT: begin
                    if (byte_ok && (rx_data == SYNC_BYTE)) begin
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (byte_ok) begin
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (byte_ok) begin
                        if (rx_data > MAX_LEN_B) begin
                            state_d   = ST_HUNT;
                            err_len_d = 1'b1;
                        end else if (rx_data == 8'h00) begin
                            state_d = ST_CHK;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (byte_ok && (idx_q == (len_q - 8'd1))) begin
                        state_d = ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (byte_ok) begin
                        if (rx_data == sum_q) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d   = ST_HUNT;
                            err_chk_d = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (pkt_ack) begin
                        state_d = ST_HUNT;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end
    end

    // Packet datapath: header capture, running sum, payload index, presented
    // header copy, drop counter and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= 8'h00;
            len_q       <= 8'h00;
            sum_q       <= 8'h00;
            idx_q       <= 8'h00;
            pkt_cmd     <= 8'h00;
            pkt_len     <= 8'h00;
            drop_cnt    <= 8'h00;
            err_chk_q   <= 1'b0;
            err_len_q   <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            err_chk_q   <= err_chk_d;
            err_len_q   <= err_len_d;
            err_frame_q <= err_frame_d;
            case (state_q)
                ST_CMD: begin
                    if (byte_ok) begin
                        cmd_q <= rx_data;
                        sum_q <= rx_data;
                    end
                end
                ST_LEN: begin
                    if (byte_ok) begin
                        len_q <= rx_data;
                        sum_q <= sum_q + rx_data;
                        idx_q <= 8'h00;
                    end
                end
                ST_PAYLOAD: begin
                    if (byte_ok) begin
                        sum_q <= sum_q + rx_data;
                        idx_q <= idx_q + 8'd1;
                    end
                end
                ST_CHK: begin
                    if (byte_ok && (rx_data == sum_q)) begin
                        pkt_cmd <= cmd_q;
                        pkt_len <= len_q;
                    end
                end
                ST_HOLD: begin
                    if (rx_valid && (drop_cnt != 8'hFF)) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Payload buffer; contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if ((state_q == ST_PAYLOAD) && byte_ok) begin
            pay_mem[idx_q[IDX_W-1:0]] <= rx_data;
        end
    end

    assign rd_data     = (rd_addr < MAX_LEN_B) ? pay_mem[rd_addr[IDX_W-1:0]] : 8'h00;
    assign pkt_valid   = (state_q == ST_HOLD);
    assign err_chk     = err_chk_q;
    assign err_len     = err_len_q;
    assign err_frame   = err_frame_q;
    assign state       = state_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: good/bad packets, length limit,
// maximum-length payload, sync-as-data, timeout (either build), drop
// saturation, frame errors and asynchronous reset mid-packet.
`timescale 1ns/1ps

module tb_uart_cmd_parser;

    localparam int T_CYC = 8680;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ferr = 1'b0;
    logic       pkt_valid;
    logic       pkt_ack = 1'b0;
    logic [7:0] pkt_cmd;
    logic [7:0] pkt_len;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_data;
    logic       err_chk;
    logic       err_len;
    logic       err_frame;
    logic       err_timeout;
    logic [7:0] drop_cnt;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;
    int n_err_pulses = 0;
    int n_tmo_pulses = 0;

    uart_cmd_parser dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ferr     (rx_ferr),
        .pkt_valid   (pkt_valid),
        .pkt_ack     (pkt_ack),
        .pkt_cmd     (pkt_cmd),
        .pkt_len     (pkt_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_frame   (err_frame),
        .err_timeout (err_timeout),
        .drop_cnt    (drop_cnt),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Count every error pulse cycle seen at a clock edge (pre-edge values).
    always @(posedge clk) begin
        if (err_chk || err_len || err_frame || err_timeout) n_err_pulses++;
        if (err_timeout) n_tmo_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic pulse_ferr();
        @(negedge clk);
        rx_ferr = 1'b1;
        @(negedge clk);
        rx_ferr = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk);
        pkt_ack = 1'b1;
        @(negedge clk);
        pkt_ack = 1'b0;
    endtask

    task automatic read_buf(input logic [7:0] addr, output logic [7:0] val);
        rd_addr = addr;
        #1;
        val = rd_data;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] acc;
        int         base;
        int         seen;

        // Reset values
        #23;
        check("rst pkt_valid", 32'(pkt_valid), 32'd0);
        check("rst pkt_cmd", 32'(pkt_cmd), 32'd0);
        check("rst pkt_len", 32'(pkt_len), 32'd0);
        check("rst errs", 32'({err_chk, err_len, err_frame, err_timeout}), 32'd0);
        check("rst drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst state", 32'(state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Good packet AA 10 02 01 02 15
        send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02);
        check("pkt1 state before chk", 32'(state), 32'd4);
        check("pkt1 valid before chk", 32'(pkt_valid), 32'd0);
        send_byte(8'h15);
        check("pkt1 valid", 32'(pkt_valid), 32'd1);
        check("pkt1 cmd", 32'(pkt_cmd), 32'h10);
        check("pkt1 len", 32'(pkt_len), 32'd2);
        read_buf(8'd0, v);  check("pkt1 rd0", 32'(v), 32'h01);
        read_buf(8'd1, v);  check("pkt1 rd1", 32'(v), 32'h02);
        read_buf(8'd16, v); check("rd out of range 16", 32'(v), 32'h00);
        do_ack();
        check("pkt1 valid after ack", 32'(pkt_valid), 32'd0);
        check("pkt1 state after ack", 32'(state), 32'd0);

        // Bad checksum, then zero-length packet
        send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h16);
        check("bad chk err_chk", 32'(err_chk), 32'd1);
        check("bad chk valid", 32'(pkt_valid), 32'd0);
        check("bad chk state", 32'(state), 32'd0);
        @(negedge clk);
        check("bad chk pulse width", 32'(err_chk), 32'd0);
        send_byte(8'hAA); send_byte(8'h20); send_byte(8'h00);
        check("len0 state", 32'(state), 32'd4);
        send_byte(8'h20);
        check("len0 valid", 32'(pkt_valid), 32'd1);
        check("len0 cmd", 32'(pkt_cmd), 32'h20);
        check("len0 len", 32'(pkt_len), 32'd0);
        do_ack();

        // Length over limit, then junk bytes raise nothing
        send_byte(8'hAA); send_byte(8'h30); send_byte(8'h11);
        check("len err_len", 32'(err_len), 32'd1);
        check("len state", 32'(state), 32'd0);
        @(negedge clk);
        check("len pulse width", 32'(err_len), 32'd0);
        @(negedge clk);
        base = n_err_pulses;
        send_byte(8'h55); send_byte(8'h00); send_byte(8'h11); send_byte(8'hFF);
        @(negedge clk); @(negedge clk);
        check("hunt junk no errors", 32'(n_err_pulses - base), 32'd0);
        check("hunt junk state", 32'(state), 32'd0);

        // Maximum length payload (16 bytes)
        send_byte(8'hAA); send_byte(8'h31); send_byte(8'h10);
        acc = 8'h31 + 8'h10;
        for (int i = 0; i < 16; i++) begin
            v = 8'(i * 7 + 3);
            acc = acc + v;
            send_byte(v);
        end
        check("max len state", 32'(state), 32'd4);
        send_byte(acc);
        check("max len valid", 32'(pkt_valid), 32'd1);
        check("max len len", 32'(pkt_len), 32'd16);
        read_buf(8'd0, v);   check("max len rd0", 32'(v), 32'h03);
        read_buf(8'd15, v);  check("max len rd15", 32'(v), 32'(8'(15 * 7 + 3)));
        read_buf(8'd255, v); check("rd out of range 255", 32'(v), 32'h00);
        do_ack();

        // Sync byte value inside a packet is data
        send_byte(8'hAA); send_byte(8'h50); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hFB);
        check("sync as data valid", 32'(pkt_valid), 32'd1);
        check("sync as data cmd", 32'(pkt_cmd), 32'h50);
        read_buf(8'd0, v); check("sync as data rd0", 32'(v), 32'hAA);
        do_ack();

        // Inter-byte timeout
        base = n_tmo_pulses;
        send_byte(8'hAA); send_byte(8'h40);
`ifdef UART_CMD_PARSER_TIMEOUT_EN
        seen = 0;
        for (int k = 1; k <= T_CYC + 10; k++) begin
            @(posedge clk);
            #1;
            if (err_timeout) begin
                seen = k;
                break;
            end
        end
        check("timeout latency", 32'(seen), 32'(T_CYC));
        check("timeout state", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        check("timeout pulse width", 32'(err_timeout), 32'd0);
        repeat (20) @(negedge clk);
        check("timeout single pulse", 32'(n_tmo_pulses - base), 32'd1);
`else
        seen = 0;
        repeat (T_CYC + 20) @(negedge clk);
        check("no timeout state", 32'(state), 32'd2);
        check("no timeout pulses", 32'(n_tmo_pulses - base), 32'd0);
        pulse_ferr();
        check("stall ferr err_frame", 32'(err_frame), 32'd1);
        check("stall ferr state", 32'(state), 32'd0);
`endif

        // Held packet: 300 dropped bytes saturate drop_cnt
        send_byte(8'hAA); send_byte(8'h60); send_byte(8'h01);
        send_byte(8'h5A); send_byte(8'hBB);
        check("hold valid", 32'(pkt_valid), 32'd1);
        for (int i = 0; i < 300; i++) begin
            send_byte(8'(i));
            if (i == 253) check("drop cnt 254", 32'(drop_cnt), 32'd254);
        end
        check("drop cnt saturated", 32'(drop_cnt), 32'd255);
        check("hold valid after drops", 32'(pkt_valid), 32'd1);
        check("hold cmd stable", 32'(pkt_cmd), 32'h60);
        check("hold len stable", 32'(pkt_len), 32'd1);
        read_buf(8'd0, v); check("hold rd0 stable", 32'(v), 32'h5A);
        do_ack();
        check("drop cnt kept after ack", 32'(drop_cnt), 32'd255);

        // Frame error in payload
        send_byte(8'hAA); send_byte(8'h70); send_byte(8'h03); send_byte(8'h01);
        pulse_ferr();
        check("ferr payload err_frame", 32'(err_frame), 32'd1);
        check("ferr payload state", 32'(state), 32'd0);
        @(negedge clk);
        check("ferr pulse width", 32'(err_frame), 32'd0);

        // Frame error with a byte in CHK position: byte discarded
        send_byte(8'hAA); send_byte(8'h71); send_byte(8'h00);
        @(negedge clk);
        rx_data = 8'h71; rx_valid = 1'b1; rx_ferr = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; rx_ferr = 1'b0;
        check("ferr+valid err_frame", 32'(err_frame), 32'd1);
        check("ferr+valid no packet", 32'(pkt_valid), 32'd0);

        // Frame error in HUNT is ignored
        @(negedge clk);
        base = n_err_pulses;
        pulse_ferr();
        @(negedge clk); @(negedge clk);
        check("ferr in hunt ignored", 32'(n_err_pulses - base), 32'd0);

        // Reset mid-payload
        send_byte(8'hAA); send_byte(8'h80); send_byte(8'h04);
        send_byte(8'h01); send_byte(8'h02);
        check("pre-reset state", 32'(state), 32'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid rst state", 32'(state), 32'd0);
        check("mid rst pkt_cmd", 32'(pkt_cmd), 32'd0);
        check("mid rst drop_cnt", 32'(drop_cnt), 32'd0);
        check("mid rst valid", 32'(pkt_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h03); send_byte(8'h04); send_byte(8'h8E);
        check("partial not presented", 32'(pkt_valid), 32'd0);
        check("partial state", 32'(state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
